// File: rtl/occ_gtpe2_link_ctrl_if.sv
// ============================================================================
// Module      : occ_gtpe2_link_ctrl_if
// Description : Signal bundle between the link bring-up controller and a
//               GTPE2 transceiver channel plus its PLL.
//               master : controller side (drives PLL/GT resets, comma enable)
//               slave  : transceiver side (drives lock, reset-done, RX status)
//   pll_lock_i        PLL lock (asynchronous to the controller clock)
//   pll_rst_o         PLL reset
//   rxreset_o         GT RX reset pulse
//   txreset_o         GT TX reset pulse
//   rxresetdone_i     GT RX reset done
//   txresetdone_i     GT TX reset done
//   rxencommaalign_o  comma alignment enable
//   rxcharisk_i       [1:0] per-byte K flag
//   rxdisperr_i       [1:0] per-byte disparity error
//   rxnotintable_i    [1:0] per-byte not-in-table error
//   rxdata_i          [15:0] RX data
//   rxbufstatus_i     [2:0] elastic buffer status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface occ_gtpe2_link_ctrl_if;
   logic        pll_lock_i;
   logic        pll_rst_o;
   logic        rxreset_o;
   logic        txreset_o;
   logic        rxresetdone_i;
   logic        txresetdone_i;
   logic        rxencommaalign_o;
   logic [1:0]  rxcharisk_i;
   logic [1:0]  rxdisperr_i;
   logic [1:0]  rxnotintable_i;
   logic [15:0] rxdata_i;
   logic [2:0]  rxbufstatus_i;

   modport master (
      input  pll_lock_i, rxresetdone_i, txresetdone_i,
             rxcharisk_i, rxdisperr_i, rxnotintable_i, rxdata_i, rxbufstatus_i,
      output pll_rst_o, rxreset_o, txreset_o, rxencommaalign_o
   );

   modport slave (
      output pll_lock_i, rxresetdone_i, txresetdone_i,
             rxcharisk_i, rxdisperr_i, rxnotintable_i, rxdata_i, rxbufstatus_i,
      input  pll_rst_o, rxreset_o, txreset_o, rxencommaalign_o
   );
endinterface

`default_nettype wire

// File: rtl/occ_gtpe2_link_ctrl.sv
// ============================================================================
// Module      : occ_gtpe2_link_ctrl
// Description : GTPE2 link bring-up sequencer. Resets the PLL, waits for lock,
//               pulses the GT resets, waits for reset-done, lets the channel
//               settle, enables comma alignment and declares link up after a
//               run of clean commas. Timeouts and faults restart the sequence
//               and are counted in retry_cnt_o.
//   clk_i        GT user clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   restart_i    synchronous request to restart the full bring-up
//   gt           transceiver bundle (master modport)
//   link_up_o    high while in READY
//   state_o      [2:0] current state code
//   retry_cnt_o  [7:0] saturating count of timeout/fault restarts
//   err_cnt_o    [15:0] code-error cycles in READY (only with
//                OCC_GTPE2_LINK_CTRL_ERRCNT_EN defined)
// Optional feature macro: OCC_GTPE2_LINK_CTRL_ERRCNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module occ_gtpe2_link_ctrl #(
   parameter int g_PLL_RST_CYCLES = 200,
   parameter int g_SETTLE_CYCLES  = 1000,
   parameter int g_TIMEOUT_CYCLES = 65535,
   parameter int g_COMMA_COUNT    = 4
) (
   input  wire logic              clk_i,
   input  wire logic              rst_n_i,
   input  wire logic              restart_i,
   occ_gtpe2_link_ctrl_if.master  gt,
   output logic                   link_up_o,
   output logic [2:0]             state_o,
   output logic [7:0]             retry_cnt_o
`ifdef OCC_GTPE2_LINK_CTRL_ERRCNT_EN
   ,
   output logic [15:0]            err_cnt_o
`endif
);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_GT_RST    = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_SETTLE    = 3'd4,
      S_ALIGN     = 3'd5,
      S_READY     = 3'd6
   } state_t;

   localparam logic [31:0] c_PLL_LAST    = 32'(g_PLL_RST_CYCLES - 1);
   localparam logic [31:0] c_SETTLE_LAST = 32'(g_SETTLE_CYCLES - 1);
   localparam logic [31:0] c_TIMEOUT_LAST = 32'(g_TIMEOUT_CYCLES - 1);
   localparam int          c_CC_W        = $clog2(g_COMMA_COUNT + 1);
   localparam logic [c_CC_W-1:0] c_CC_LAST = c_CC_W'(g_COMMA_COUNT - 1);

   state_t             state;
   state_t             state_nxt;
   logic               retry_inc;
   logic [31:0]        cnt;
   logic [c_CC_W-1:0]  comma_cnt;
   logic [1:0]         lock_sync;
   logic               lock_s;
   logic               lock_lost;
   logic               code_err;
   logic               comma;

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) lock_sync <= 2'b00;
      else          lock_sync <= {lock_sync[0], gt.pll_lock_i};
   end
   assign lock_s = lock_sync[1];

   assign code_err = (|gt.rxdisperr_i) | (|gt.rxnotintable_i);
   assign comma    = (gt.rxcharisk_i == 2'b10) && (gt.rxdata_i == 16'hBC95) && !code_err;

   // Losing lock only matters once lock has been acquired.
   assign lock_lost = !lock_s && (state != S_PLL_RST) && (state != S_WAIT_LOCK);

   always_comb begin
      state_nxt = state;
      retry_inc = 1'b0;
      if (restart_i) begin
         state_nxt = S_PLL_RST;
      end else if (lock_lost) begin
         state_nxt = S_PLL_RST;
         retry_inc = 1'b1;
      end else begin
         case (state)
            S_PLL_RST:   if (cnt == c_PLL_LAST) state_nxt = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = S_GT_RST;
               end else if (cnt == c_TIMEOUT_LAST) begin
                  state_nxt = S_PLL_RST;
                  retry_inc = 1'b1;
               end
            end
            S_GT_RST:    state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
               if (gt.rxresetdone_i && gt.txresetdone_i) begin
                  state_nxt = S_SETTLE;
               end else if (cnt == c_TIMEOUT_LAST) begin
                  state_nxt = S_GT_RST;
                  retry_inc = 1'b1;
               end
            end
            S_SETTLE:    if (cnt == c_SETTLE_LAST) state_nxt = S_ALIGN;
            S_ALIGN: begin
               // The comma that completes the run wins over a coincident timeout.
               if (comma && (comma_cnt == c_CC_LAST)) begin
                  state_nxt = S_READY;
               end else if (cnt == c_TIMEOUT_LAST) begin
                  state_nxt = S_GT_RST;
                  retry_inc = 1'b1;
               end
            end
            S_READY: begin
               if (gt.rxbufstatus_i[2]) begin
                  state_nxt = S_GT_RST;
                  retry_inc = 1'b1;
               end
            end
            default:     state_nxt = S_PLL_RST;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= S_PLL_RST;
         cnt         <= 32'd0;
         comma_cnt   <= '0;
         retry_cnt_o <= 8'd0;
      end else begin
         state <= state_nxt;
         // A restart re-enters PLL_RST even from PLL_RST, so it also clears.
         if ((state_nxt != state) || restart_i) cnt <= 32'd0;
         else if (cnt != '1)                    cnt <= cnt + 32'd1;

         if ((state != S_ALIGN) || (state_nxt != S_ALIGN)) comma_cnt <= '0;
         else if (code_err)                                comma_cnt <= '0;
         else if (comma)                                   comma_cnt <= comma_cnt + 1'b1;

         if (retry_inc && (retry_cnt_o != 8'hFF)) retry_cnt_o <= retry_cnt_o + 8'd1;
      end
   end

`ifdef OCC_GTPE2_LINK_CTRL_ERRCNT_EN
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_cnt_o <= 16'd0;
      end else if ((state_nxt == S_READY) && (state != S_READY)) begin
         err_cnt_o <= 16'd0;
      end else if ((state == S_READY) && code_err && (err_cnt_o != 16'hFFFF)) begin
         err_cnt_o <= err_cnt_o + 16'd1;
      end
   end
`endif

   // Outputs decode the registered state so they change with it.
   assign gt.pll_rst_o        = (state == S_PLL_RST);
   assign gt.rxreset_o        = (state == S_GT_RST);
   assign gt.txreset_o        = (state == S_GT_RST);
   assign gt.rxencommaalign_o = (state == S_ALIGN) || (state == S_READY);
   assign link_up_o           = (state == S_READY);
   assign state_o             = state;

endmodule

`default_nettype wire

// File: tb/tb_occ_gtpe2_link_ctrl.sv
// ============================================================================
// Module      : tb_occ_gtpe2_link_ctrl
// Description : Self-checking bench for occ_gtpe2_link_ctrl. A transceiver
//               emulator answers the controller, a behavioural model predicts
//               every output each cycle, and directed scenarios pin the model
//               with hand-computed values. Honours
//               OCC_GTPE2_LINK_CTRL_ERRCNT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_occ_gtpe2_link_ctrl;

   localparam int P_PLL    = 20;
   localparam int P_SETTLE = 30;
   localparam int P_TO     = 400;
   localparam int P_CC     = 4;

   // State codes as listed for state_o.
   localparam int M_PLL_RST = 0, M_WAIT_LOCK = 1, M_GT_RST = 2, M_WAIT_DONE = 3;
   localparam int M_SETTLE = 4, M_ALIGN = 5, M_READY = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        restart = 1'b0;
   logic        link_up;
   logic [2:0]  state;
   logic [7:0]  retry;
`ifdef OCC_GTPE2_LINK_CTRL_ERRCNT_EN
   logic [15:0] err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   occ_gtpe2_link_ctrl_if gt_if ();

   occ_gtpe2_link_ctrl #(
      .g_PLL_RST_CYCLES (P_PLL),
      .g_SETTLE_CYCLES  (P_SETTLE),
      .g_TIMEOUT_CYCLES (P_TO),
      .g_COMMA_COUNT    (P_CC)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .restart_i   (restart),
      .gt          (gt_if),
      .link_up_o   (link_up),
      .state_o     (state),
      .retry_cnt_o (retry)
`ifdef OCC_GTPE2_LINK_CTRL_ERRCNT_EN
      ,
      .err_cnt_o   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- emulator
   bit          lock_allow = 1'b1;
   int          lock_dly = 50;
   int          done_dly = 20;
   int          comma_period = 32;
   int          err_pct = 0;
   bit          manual_rx = 1'b0;
   logic [1:0]  man_k = 2'b00, man_de = 2'b00, man_nit = 2'b00;
   logic [15:0] man_d = 16'h0000;

   initial begin
      int since_pll = 0;
      int since_pulse = 0;
      int word = 0;
      gt_if.pll_lock_i     = 1'b0;
      gt_if.rxresetdone_i  = 1'b0;
      gt_if.txresetdone_i  = 1'b0;
      gt_if.rxcharisk_i    = 2'b00;
      gt_if.rxdisperr_i    = 2'b00;
      gt_if.rxnotintable_i = 2'b00;
      gt_if.rxdata_i       = 16'h0000;
      forever begin
         @(negedge clk); #2;
         if (gt_if.pll_rst_o) since_pll = 0; else if (since_pll < 1000000) since_pll++;
         gt_if.pll_lock_i = lock_allow && !gt_if.pll_rst_o && (since_pll >= lock_dly);
         if (gt_if.rxreset_o) since_pulse = 0; else if (since_pulse < 1000000) since_pulse++;
         gt_if.rxresetdone_i = (since_pulse >= done_dly);
         gt_if.txresetdone_i = (since_pulse >= done_dly);
         if (manual_rx) begin
            gt_if.rxcharisk_i    = man_k;
            gt_if.rxdata_i       = man_d;
            gt_if.rxdisperr_i    = man_de;
            gt_if.rxnotintable_i = man_nit;
         end else begin
            word++;
            gt_if.rxdisperr_i    = 2'b00;
            gt_if.rxnotintable_i = 2'b00;
            if (word % comma_period == 0) begin
               gt_if.rxcharisk_i = 2'b10;
               gt_if.rxdata_i    = 16'hBC95;
            end else begin
               gt_if.rxcharisk_i = 2'b00;
               gt_if.rxdata_i    = 16'($urandom);
            end
            if (err_pct > 0 && $urandom_range(99) < err_pct) begin
               if ($urandom_range(1) == 0) gt_if.rxdisperr_i    = 2'($urandom_range(3, 1));
               else                        gt_if.rxnotintable_i = 2'($urandom_range(3, 1));
            end
         end
      end
   end

   // ------------------------------------------------------------------ model
   // Tracks the bring-up in terms of "which phase are we in and how many
   // clocks have we spent there", with timestamps rather than counters.
   int        m_state = M_PLL_RST;
   int        m_edge = 0;         // index of the next evaluated clock edge
   int        m_entry = 0;        // edge index of the first clock spent in m_state
   int        m_retry = 0;
   int        m_commas = 0;
   int        m_err = 0;
   bit        m_lock_d1 = 1'b0, m_lock_d2 = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = M_PLL_RST; m_entry = m_edge; m_retry = 0; m_commas = 0; m_err = 0;
         m_lock_d1 = 1'b0; m_lock_d2 = 1'b0;
      end else begin
         int  here;
         int  nxt;
         bit  bump;
         bit  lock;
         bit  bad;
         bit  is_comma;
         here = m_edge - m_entry;
         lock = m_lock_d2;
         bad = (gt_if.rxdisperr_i != 0) || (gt_if.rxnotintable_i != 0);
         is_comma = (gt_if.rxcharisk_i == 2'b10) && (gt_if.rxdata_i == 16'hBC95) && !bad;
         nxt = m_state;
         bump = 1'b0;
         if (restart) nxt = M_PLL_RST;
         else if (m_state >= M_GT_RST && !lock) begin nxt = M_PLL_RST; bump = 1'b1; end
         else if (m_state == M_PLL_RST && here + 1 == P_PLL) nxt = M_WAIT_LOCK;
         else if (m_state == M_WAIT_LOCK && lock) nxt = M_GT_RST;
         else if (m_state == M_WAIT_LOCK && here + 1 == P_TO) begin nxt = M_PLL_RST; bump = 1'b1; end
         else if (m_state == M_GT_RST) nxt = M_WAIT_DONE;
         else if (m_state == M_WAIT_DONE && gt_if.rxresetdone_i && gt_if.txresetdone_i) nxt = M_SETTLE;
         else if (m_state == M_WAIT_DONE && here + 1 == P_TO) begin nxt = M_GT_RST; bump = 1'b1; end
         else if (m_state == M_SETTLE && here + 1 == P_SETTLE) nxt = M_ALIGN;
         else if (m_state == M_ALIGN && is_comma && m_commas + 1 == P_CC) nxt = M_READY;
         else if (m_state == M_ALIGN && here + 1 == P_TO) begin nxt = M_GT_RST; bump = 1'b1; end
         else if (m_state == M_READY && gt_if.rxbufstatus_i[2]) begin nxt = M_GT_RST; bump = 1'b1; end

         if (m_state == M_ALIGN && nxt == M_ALIGN) m_commas = bad ? 0 : m_commas + (is_comma ? 1 : 0);
         else m_commas = 0;
         if (nxt == M_READY && m_state != M_READY) m_err = 0;
         else if (m_state == M_READY && bad) m_err = (m_err < 65535) ? m_err + 1 : 65535;
         if (bump) m_retry = (m_retry < 255) ? m_retry + 1 : 255;
         if (nxt != m_state || restart) m_entry = m_edge + 1;
         m_state = nxt;
         m_edge++;
         m_lock_d2 = m_lock_d1;
         m_lock_d1 = gt_if.pll_lock_i;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [2:0] e_state;
      e_state = 3'(m_state);
      checks++;
      if (state !== e_state || gt_if.pll_rst_o !== (m_state == M_PLL_RST) ||
          gt_if.rxreset_o !== (m_state == M_GT_RST) || gt_if.txreset_o !== (m_state == M_GT_RST) ||
          gt_if.rxencommaalign_o !== (m_state >= M_ALIGN) || link_up !== (m_state == M_READY) ||
          retry !== 8'(m_retry)) begin
         errors++;
         $display("FAIL model t=%0t: state %0d pll_rst %b rxrst %b txrst %b align %b up %b retry %0d, required state %0d retry %0d",
                  $time, state, gt_if.pll_rst_o, gt_if.rxreset_o, gt_if.txreset_o,
                  gt_if.rxencommaalign_o, link_up, retry, m_state, m_retry);
      end
`ifdef OCC_GTPE2_LINK_CTRL_ERRCNT_EN
      checks++;
      if (err_cnt !== 16'(m_err)) begin
         errors++;
         $display("FAIL model_errcnt t=%0t: err_cnt %0d required %0d", $time, err_cnt, m_err);
      end
`endif
   end

   // ------------------------------------------------------------- directed
   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic wait_state(input int s, input int budget, input string name);
      int n = 0;
      while (int'(state) != s && n < budget) begin tick(); n++; end
      check(name, int'(state), s);
   endtask

   task automatic send_word(input logic [1:0] k, input logic [15:0] d,
                            input logic [1:0] de, input logic [1:0] nit);
      man_k = k; man_d = d; man_de = de; man_nit = nit;
      tick();
   endtask

   task automatic count_pll_rst(input string name);
      int n = 0;
      while (gt_if.pll_rst_o && n < 1000) begin tick(); n++; end
      check(name, n, P_PLL);
   endtask

   initial begin
      int n;
      gt_if.rxbufstatus_i = 3'b000;
      repeat (3) tick();
      check("reset_state", int'(state), M_PLL_RST);
      check("reset_pll_rst", int'(gt_if.pll_rst_o), 1);
      check("reset_gt_rst", int'({gt_if.rxreset_o, gt_if.txreset_o, gt_if.rxencommaalign_o}), 0);
      check("reset_link_retry", int'({link_up, retry}), 0);

      // Nominal bring-up.
      rst_n = 1'b1;
      count_pll_rst("pll_rst_hold");
      n = 0;
      while (!gt_if.rxreset_o && n < 200) begin tick(); n++; end
      check("gt_rst_pulse_hi", int'({gt_if.rxreset_o, gt_if.txreset_o}), 3);
      tick();
      check("gt_rst_pulse_lo", int'({gt_if.rxreset_o, gt_if.txreset_o}), 0);
      wait_state(M_READY, 1000, "bringup_ready");
      check("bringup_link_up", int'(link_up), 1);
      check("bringup_retry", int'(retry), 0);

      // Code errors in READY do not drop the link.
      err_pct = 5;
      repeat (200) tick();
      err_pct = 0;
      check("ready_with_errors", int'(state), M_READY);

      // Elastic buffer fault.
      gt_if.rxbufstatus_i = 3'b101;
      tick();
      gt_if.rxbufstatus_i = 3'b000;
      check("bufstat_link_down", int'(link_up), 0);
      check("bufstat_state", int'(state), M_GT_RST);
      check("bufstat_retry", int'(retry), 1);
      wait_state(M_READY, 1000, "bufstat_recover");

      // Lock loss and restart in the same cycle: restart wins.
      lock_allow = 1'b0;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      lock_allow = 1'b1;
      check("restart_state", int'(state), M_PLL_RST);
      check("restart_retry", int'(retry), 1);
      wait_state(M_READY, 1000, "restart_recover");

      // Lock never arrives: WAIT_LOCK times out.
      lock_allow = 1'b0;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      wait_state(M_WAIT_LOCK, 100, "to_enter_wait_lock");
      n = 0;
      while (int'(state) == M_WAIT_LOCK && n < 2 * P_TO) begin tick(); n++; end
      check("to_wait_lock_len", n, P_TO);
      check("to_state", int'(state), M_PLL_RST);
      check("to_retry", int'(retry), 2);
      lock_allow = 1'b1;

      // Comma run broken by a disparity error on the third comma.
      manual_rx = 1'b1;
      man_k = 2'b00; man_d = 16'h0000; man_de = 2'b00; man_nit = 2'b00;
      wait_state(M_ALIGN, 1000, "align_enter");
      send_word(2'b10, 16'hBC95, 2'b00, 2'b00);
      send_word(2'b00, 16'h1234, 2'b00, 2'b00);
      send_word(2'b10, 16'hBC95, 2'b00, 2'b00);
      send_word(2'b00, 16'h1234, 2'b00, 2'b00);
      send_word(2'b10, 16'hBC95, 2'b01, 2'b00);
      send_word(2'b00, 16'h1234, 2'b00, 2'b00);
      for (int i = 0; i < 3; i++) begin
         send_word(2'b10, 16'hBC95, 2'b00, 2'b00);
         send_word(2'b00, 16'h1234, 2'b00, 2'b00);
      end
      check("align_three_after_err", int'(state), M_ALIGN);
      send_word(2'b10, 16'hBC95, 2'b00, 2'b00);
      check("align_fourth_ready", int'(state), M_READY);
      send_word(2'b00, 16'h1234, 2'b00, 2'b00);
`ifdef OCC_GTPE2_LINK_CTRL_ERRCNT_EN
      for (int i = 0; i < 10; i++) send_word(2'b00, 16'h1234, 2'b00, 2'b01);
      send_word(2'b00, 16'h1234, 2'b00, 2'b00);
      check("errcnt_ten", int'(err_cnt), 10);
      check("errcnt_link_up", int'(link_up), 1);
`endif
      manual_rx = 1'b0;

      // Randomised traffic and faults, model-checked every cycle.
      for (int it = 0; it < 6000; it++) begin
         tick();
         if (it % 1500 == 0) begin
            lock_dly     = $urandom_range(80, 1);
            done_dly     = $urandom_range(60, 1);
            comma_period = $urandom_range(48, 8);
            err_pct      = $urandom_range(3, 0);
         end
         restart = ($urandom_range(999) == 0);
         gt_if.rxbufstatus_i = ($urandom_range(499) == 0) ? 3'b100 | 3'($urandom_range(3))
                                                          : 3'($urandom_range(3));
         if (lock_allow && $urandom_range(799) == 0) lock_allow = 1'b0;
         else if (!lock_allow && $urandom_range(30) == 0) lock_allow = 1'b1;
      end
      restart = 1'b0;
      gt_if.rxbufstatus_i = 3'b000;
      lock_allow = 1'b1;
      err_pct = 0;
      comma_period = 32;
      wait_state(M_READY, 3000, "random_final_ready");

      // Reset in the middle of operation restarts with a full PLL hold.
      rst_n = 1'b0;
      tick();
      check("midreset_state", int'(state), M_PLL_RST);
      check("midreset_retry", int'(retry), 0);
      tick();
      rst_n = 1'b1;
      count_pll_rst("midreset_pll_hold");
      wait_state(M_READY, 1000, "midreset_ready");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/occ_gtpe2_link_ctrl.md
OCC_GTPE2_LINK_CTRL -- requirements
Module: occ_gtpe2_link_ctrl

Interface
REQ-001 Parameter g_PLL_RST_CYCLES, default 200: cycles pll_rst_o is held high per PLL reset.
REQ-002 Parameter g_SETTLE_CYCLES, default 1000: cycles waited after both resetdone before comma alignment.
REQ-003 Parameter g_TIMEOUT_CYCLES, default 65535: per-state wait limit in WAIT_LOCK, WAIT_DONE, ALIGN.
REQ-004 Parameter g_COMMA_COUNT, default 4: clean commas required to declare link up.
REQ-005 clk_i  in  1  sole clock (GT usrclk); all logic on rising edge.
REQ-006 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-007 restart_i  in  1  synchronous request to restart full bring-up.
REQ-008 pll_lock_i  in  1  PLL lock, asynchronous; 2-FF synchronised internally.
REQ-009 pll_rst_o  out  1  PLL reset.
REQ-010 rxreset_o, txreset_o  out  1 each  GT RX/TX reset pulses.
REQ-011 rxresetdone_i, txresetdone_i  in  1 each  GT reset-done flags.
REQ-012 rxencommaalign_o  out  1  comma alignment enable.
REQ-013 rxcharisk_i, rxdisperr_i, rxnotintable_i  in  2 each  per-byte RX status.
REQ-014 rxdata_i  in  16  RX data; rxbufstatus_i  in  3  elastic buffer status.
REQ-015 link_up_o  out  1  high only in READY.
REQ-016 state_o  out  3  encoded state (PLL_RST=0, WAIT_LOCK=1, GT_RST=2, WAIT_DONE=3, SETTLE=4, ALIGN=5, READY=6).
REQ-017 retry_cnt_o  out  8  saturating count of timeout/fault restarts.

Function
REQ-018 Comma defined as rxcharisk_i==2'b10 and rxdata_i==16'hBC95 with rxdisperr_i==0 and rxnotintable_i==0; code error defined as rxdisperr_i!=0 or rxnotintable_i!=0.
REQ-019 PLL_RST: pll_rst_o=1 for exactly g_PLL_RST_CYCLES cycles, then WAIT_LOCK with pll_rst_o=0.
REQ-020 WAIT_LOCK: synced lock=1 -> GT_RST; g_TIMEOUT_CYCLES elapsed -> PLL_RST, retry_cnt_o+1.
REQ-021 GT_RST: rxreset_o and txreset_o high together for exactly one cycle, then WAIT_DONE.
REQ-022 WAIT_DONE: rxresetdone_i and txresetdone_i both high in same cycle -> SETTLE; timeout -> GT_RST, retry+1.
REQ-023 SETTLE: wait g_SETTLE_CYCLES cycles -> ALIGN.
REQ-024 ALIGN: rxencommaalign_o=1; clean-comma counter increments per comma, clears on code error; reaching g_COMMA_COUNT -> READY next cycle; timeout -> GT_RST, retry+1.
REQ-025 READY: rxencommaalign_o stays 1; link_up_o=1; rxbufstatus_i[2]==1 -> GT_RST, retry+1; code errors do not leave READY.
REQ-026 Synced lock=0 in any state after WAIT_LOCK -> PLL_RST, retry+1; takes priority over all other transitions except restart_i.
REQ-027 restart_i=1 in any state -> PLL_RST next cycle, retry_cnt_o unchanged; highest priority.
REQ-028 State counter clears on every state entry; retry_cnt_o saturates at 255.
REQ-029 link_up_o drops in the same cycle state leaves READY (registered with state).

Reset
REQ-030 On rst_n_i low: state PLL_RST, pll_rst_o=1, rxreset_o=0, txreset_o=0, rxencommaalign_o=0, link_up_o=0, retry_cnt_o=0, counters 0, lock synchroniser 0.
REQ-031 Reset deassertion mid-operation restarts full sequence from PLL_RST with a full g_PLL_RST_CYCLES hold.

Configuration
REQ-032 Macro OCC_GTPE2_LINK_CTRL_ERRCNT_EN defined: adds output err_cnt_o (16 bits, reset 0) counting cycles with a code error while in READY, saturating at 16'hFFFF, cleared on READY entry.
REQ-033 Macro undefined: err_cnt_o port and counter absent; all other behaviour identical.

Verification
REQ-034 Lock asserted 50 cycles after pll_rst_o falls, resetdone 20 cycles after pulse, commas every 32 words -> READY reached, link_up_o=1, retry_cnt_o=0, single-cycle rx/txreset pulse observed.
REQ-035 pll_lock_i held 0 -> PLL_RST re-entered after 65535 WAIT_LOCK cycles, retry_cnt_o=1.
REQ-036 In ALIGN, disperr on 3rd comma with g_COMMA_COUNT=4 -> counter clears; READY only after 4 further clean commas.
REQ-037 In READY, rxbufstatus_i=3'b101 one cycle -> link_up_o=0 next cycle, state GT_RST, retry_cnt_o+1, recovers to READY.
REQ-038 In READY, pll_lock_i drops and restart_i pulses same cycle -> PLL_RST, retry_cnt_o unchanged.
REQ-039 With OCC_GTPE2_LINK_CTRL_ERRCNT_EN, 10 cycles of rxnotintable_i=2'b01 in READY -> err_cnt_o=10, link_up_o stays 1.
